// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB slave over an on-chip register memory with programmable
// wait states and PSLVERR on out-of-range addresses. Define APB_SLV_STRB_EN for pstrb byte-lane writes.
module apb_mem_slave #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                psel,
    input  logic                penable,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic                pwrite,
`ifdef APB_SLV_STRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    output logic                pready,
    output logic [DATA_W-1:0]   prdata,
    output logic                pslverr,
    output logic                dbg_state_o
);

    // Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by
    // access cycles (psel=1, penable=1); it completes in the cycle pready=1 and
    // commits at the following rising edge. Dropping psel/penable early aborts it.

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   prdata_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                setup_s;
    logic                access_s;
    logic                oor;
    logic                wr_en;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   rd_word;

    assign setup_s  = psel & ~penable;
    assign access_s = psel & penable;
    assign oor      = ({1'b0, paddr} >= DEPTH_L);
    assign idx      = IDX_W'(paddr);
    assign rd_word  = oor ? '0 : mem_q[idx];

    assign pready      = (state_q == ACCESS) && access_s && (wcnt_q == WAIT_L);
    assign pslverr     = pready & oor;
    assign prdata      = prdata_q;
    assign dbg_state_o = (state_q == ACCESS);
    assign wr_en       = pready & pwrite & ~oor;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (setup_s) begin
                    state_d = ACCESS;
                    wcnt_d  = '0;
                end
            end
            ACCESS: begin
                if (access_s) begin
                    if (wcnt_q == WAIT_L) begin
                        state_d = IDLE;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end else if (setup_s) begin
                    // Abort that doubles as the next transfer's setup phase.
                    state_d = ACCESS;
                    wcnt_d  = '0;
                end else begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            prdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (setup_s && !pwrite) begin
                prdata_q <= rd_word;
            end
        end
    end

    // Memory contents are deliberately left without reset.
    always_ff @(posedge pclk) begin
        if (wr_en) begin
`ifdef APB_SLV_STRB_EN
            for (int i = 0; i < DATA_W/8; i++) begin
                if (pstrb[i]) begin
                    mem_q[idx][8*i +: 8] <= pwdata[8*i +: 8];
                end
            end
`else
            mem_q[idx] <= pwdata;
`endif
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: directed and random APB transfers with a scoreboard
// queue of expected completions checked by an independent monitor.
module tb_apb_mem_slave;

  localparam int ADDR_W = 8;
`ifdef APB_SLV_STRB_EN
  localparam int DATA_W = 32;
`else
  localparam int DATA_W = 16;
`endif
  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 200;
  localparam int WAITC  = 3;

  typedef struct packed {
    logic              is_rd;
    logic              err;
    logic [DATA_W-1:0] data;
    logic [31:0]       cyc;
  } exp_t;

  logic              pclk;
  logic              rst;
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pwrite;
`ifdef APB_SLV_STRB_EN
  logic [STRB_W-1:0] pstrb;
`endif
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;
  logic              dbg_state_o;

  logic [$bits(exp_t)-1:0] exp_q[$];
  logic [DATA_W-1:0]       model_mem [DEPTH];
  exp_t                    mon_e;
  int                      cyc;
  int                      checks;
  int                      errors;

  apb_mem_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)
  ) dut (
    .pclk(pclk), .rst(rst), .psel(psel), .penable(penable), .paddr(paddr),
    .pwdata(pwdata), .pwrite(pwrite),
`ifdef APB_SLV_STRB_EN
    .pstrb(pstrb),
`endif
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
      psel = 1'b0;
      penable = 1'b0;
    end
  endtask

  // abort_m < 0: full transfer. abort_m >= 0: setup plus abort_m access
  // cycles, then the caller's next action abandons it.
  task automatic xfer(input logic [ADDR_W-1:0] a, input logic wr,
                      input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s,
                      input int abort_m);
    exp_t e;
    int   n;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d;
`ifdef APB_SLV_STRB_EN
    pstrb = s;
`endif
    if (abort_m >= 0) begin
      repeat (abort_m) begin
        @(posedge pclk); #1;
        penable = 1'b1;
      end
    end else begin
      e.is_rd = ~wr;
      e.err   = (int'(a) >= DEPTH);
      e.data  = (int'(a) < DEPTH) ? model_mem[a] : '0;
      e.cyc   = 32'(cyc + 1 + WAITC);
      exp_q.push_back(e);
      if (wr && int'(a) < DEPTH) begin
        for (int i = 0; i < STRB_W; i++) begin
`ifdef APB_SLV_STRB_EN
          if (s[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
`else
          model_mem[a][8*i +: 8] = d[8*i +: 8];
`endif
        end
      end
      @(posedge pclk); #1;
      penable = 1'b1;
      n = 0;
      do begin
        @(negedge pclk);
        n++;
      end while (!pready && n < 40);
      if (!pready) begin
        checks++; errors++;
        $display("FAIL timeout addr=%0d got no pready required pready", a);
      end
    end
  endtask

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge pclk) begin
    if (!rst && pready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pready cyc=%0d got pready=1 required 0", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc != int'(mon_e.cyc)) begin
          errors++;
          $display("FAIL latency got cyc %0d required %0d", cyc, mon_e.cyc);
        end
        checks++;
        if (pslverr !== mon_e.err) begin
          errors++;
          $display("FAIL pslverr addr=%0d got %b required %b", paddr, pslverr, mon_e.err);
        end
        if (mon_e.is_rd) begin
          checks++;
          if (prdata !== mon_e.data) begin
            errors++;
            $display("FAIL prdata addr=%0d got %0h required %0h", paddr, prdata, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic              wr;
    logic [DATA_W-1:0] d;
    logic [STRB_W-1:0] s;
    logic [DATA_W-1:0] old7;
    int                ab;

    checks = 0; errors = 0;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; paddr = '0; pwdata = '0; pwrite = 1'b0;
`ifdef APB_SLV_STRB_EN
    pstrb = '0;
`endif
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("reset_pready", DATA_W'(pready), '0);
    chk("reset_pslverr", DATA_W'(pslverr), '0);
    chk("reset_prdata", prdata, '0);
    chk("reset_state", DATA_W'(dbg_state_o), '0);
    @(posedge pclk); #1;
    rst = 1'b0;

    // fill the whole memory so every later read has a known value
    for (int i = 0; i < DEPTH; i++) xfer(ADDR_W'(i), 1'b1, DATA_W'($urandom), '1, -1);

    // directed: back-to-back write/read, out-of-range, abort
    xfer(8'h00, 1'b1, DATA_W'(16'hAA55), '1, -1);
    xfer(8'h00, 1'b0, '0, '0, -1);
    xfer(8'h0B, 1'b1, DATA_W'(16'h1234), '1, -1);
    xfer(8'h0B, 1'b0, '0, '0, -1);
    xfer(8'd200, 1'b1, DATA_W'(16'hFFFF), '1, -1);
    xfer(8'd200, 1'b0, '0, '0, -1);
    xfer(8'd199, 1'b0, '0, '0, -1);
    xfer(8'd255, 1'b0, '0, '0, -1);
    xfer(8'd5, 1'b1, DATA_W'(16'hBEEF), '1, 2);
    idle(2);
    xfer(8'd5, 1'b0, '0, '0, -1);
    xfer(8'd6, 1'b1, DATA_W'(16'h0F0F), '1, 1);
    xfer(8'd6, 1'b0, '0, '0, -1);
`ifdef APB_SLV_STRB_EN
    xfer(8'd3, 1'b1, 32'h11223344, 4'hF, -1);
    xfer(8'd3, 1'b1, 32'hAABBCCDD, 4'b0101, -1);
    xfer(8'd3, 1'b0, '0, '0, -1);
    chk("strb_model", model_mem[3], 32'h11BB33DD);
    xfer(8'd3, 1'b1, 32'h0, 4'b0000, -1);
    xfer(8'd3, 1'b0, '0, '0, -1);
`endif
    idle(1);

    // reset in the middle of a write; penable held through reset must be ignored
    old7 = model_mem[7];
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 8'd7; pwrite = 1'b1; pwdata = ~old7;
    @(posedge pclk); #1;
    penable = 1'b1;
    #1 rst = 1'b1;
    @(negedge pclk);
    chk("midrst_pready", DATA_W'(pready), '0);
    chk("midrst_pslverr", DATA_W'(pslverr), '0);
    chk("midrst_prdata", prdata, '0);
    chk("midrst_state", DATA_W'(dbg_state_o), '0);
    repeat (2) @(posedge pclk);
    #1 rst = 1'b0;
    repeat (3) @(posedge pclk);
    #1 psel = 1'b0; penable = 1'b0;
    xfer(8'd7, 1'b0, '0, '0, -1);

    // random traffic with gaps, aborts and out-of-range addresses
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 3) == 0) a = ADDR_W'($urandom_range(DEPTH, 255));
      else a = ADDR_W'($urandom_range(0, DEPTH - 1));
      wr = 1'($urandom_range(0, 1));
      d  = DATA_W'($urandom);
      s  = STRB_W'($urandom);
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, WAITC)) : -1;
      xfer(a, wr, d, s, ab);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_queue got %0d entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
